// File: rtl/rx_command_sequencer_if.sv
// Receiver-side word interface: word, word-ready level and parity flag.
// The receiver drives through the master modport; the sequencer listens on slave.
interface rx_command_sequencer_if;
    logic        Data_Ready;
    logic [31:0] Data;
    logic        Parity_ERR;

    modport master (
        output Data_Ready,
        output Data,
        output Parity_ERR
    );

    modport slave (
        input Data_Ready,
        input Data,
        input Parity_ERR
    );
endinterface

// File: rtl/rx_command_sequencer.sv
// Validates received 32-bit command frames, drives motor configuration, runs a link watchdog.
// Define SOFT_RAMP_EN to make Duty slew toward the commanded target instead of jumping.
module rx_command_sequencer #(
    parameter int         DUTY_W      = 10,
    parameter int         DUTY_MAX    = 1000,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 5000000,
    parameter int         RAMP_DIV    = 5000,
    parameter int         RAMP_STEP   = 1
) (
    input  logic                     CLK,
    input  logic                     CLR,
    rx_command_sequencer_if.slave    rx,
    output logic [DUTY_W-1:0]        Duty,
    output logic                     Dir,
    output logic                     Motor_EN,
    output logic                     Fault,
    output logic                     Link_Lost,
    output logic                     Cmd_Valid,
    output logic [7:0]               Err_Count
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    localparam logic [3:0] OP_SET_DUTY    = 4'd1;
    localparam logic [3:0] OP_SET_DIR     = 4'd2;
    localparam logic [3:0] OP_ENABLE      = 4'd3;
    localparam logic [3:0] OP_DISABLE     = 4'd4;
    localparam logic [3:0] OP_ESTOP       = 4'd5;
    localparam logic [3:0] OP_HEARTBEAT   = 4'd6;
    localparam logic [3:0] OP_CLEAR_FAULT = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CHECK,
        S_EXEC,
        S_REJECT
    } state_t;

    state_t            state_q;
    logic              dr_prev_q;
    logic [7:0]        hdr_q;
    logic [3:0]        op_q;
    logic [15:0]       payload_q;
    logic              perr_q;
    logic [DUTY_W-1:0] target_q;
    logic              dir_q;
    logic              en_q;
    logic              fault_q;
    logic              lost_q;
    logic              cmd_valid_q;
    logic [7:0]        err_cnt_q;
    logic [WD_W-1:0]   wdog_q;

    logic              rise;
    logic              opcode_ok;
    logic              frame_bad;
    logic              wd_expire;
    logic [DUTY_W-1:0] duty_cmd;
    logic              unused_rsvd;

    // Reserved frame bits [19:16] are deliberately never captured.
    assign unused_rsvd = ^rx.Data[19:16];

    assign rise = rx.Data_Ready & ~dr_prev_q;

    always_comb begin
        opcode_ok = 1'b0;
        case (op_q)
            OP_SET_DUTY, OP_SET_DIR, OP_ENABLE, OP_DISABLE,
            OP_ESTOP, OP_HEARTBEAT, OP_CLEAR_FAULT: opcode_ok = 1'b1;
            default:                                opcode_ok = 1'b0;
        endcase
    end

    // ENABLE while faulted is counted as a bad frame rather than silently ignored.
    assign frame_bad = perr_q | (hdr_q != HEADER) | ~opcode_ok |
                       ((op_q == OP_ENABLE) & fault_q);

    assign duty_cmd = (32'(payload_q) > DUTY_MAX) ? DUTY_W'(DUTY_MAX) : DUTY_W'(payload_q);

    // An EXEC landing on the expiry cycle wins: the counter clears instead.
    assign wd_expire = (state_q != S_EXEC) && (wdog_q == WD_LAST);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= S_IDLE;
            dr_prev_q   <= 1'b0;
            hdr_q       <= 8'd0;
            op_q        <= 4'd0;
            payload_q   <= 16'd0;
            perr_q      <= 1'b0;
            target_q    <= '0;
            dir_q       <= 1'b0;
            en_q        <= 1'b0;
            fault_q     <= 1'b0;
            lost_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            err_cnt_q   <= 8'd0;
            wdog_q      <= '0;
        end else begin
            dr_prev_q   <= rx.Data_Ready;
            cmd_valid_q <= 1'b0;

            if (state_q == S_EXEC) begin
                wdog_q <= '0;
            end else if (wdog_q != WD_MAX) begin
                wdog_q <= wdog_q + WD_W'(1);
            end

            if (wd_expire) begin
                lost_q   <= 1'b1;
                en_q     <= 1'b0;
                target_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        hdr_q     <= rx.Data[31:24];
                        op_q      <= rx.Data[23:20];
                        payload_q <= rx.Data[15:0];
                        perr_q    <= rx.Parity_ERR;
                        state_q   <= S_LATCH;
                    end
                end
                S_LATCH: state_q <= S_CHECK;
                S_CHECK: state_q <= frame_bad ? S_REJECT : S_EXEC;
                S_EXEC: begin
                    cmd_valid_q <= 1'b1;
                    lost_q      <= 1'b0;
                    case (op_q)
                        OP_SET_DUTY:    target_q <= duty_cmd;
                        OP_SET_DIR:     dir_q    <= payload_q[0];
                        OP_ENABLE:      en_q     <= 1'b1;
                        OP_DISABLE:     en_q     <= 1'b0;
                        OP_ESTOP: begin
                            fault_q  <= 1'b1;
                            en_q     <= 1'b0;
                            target_q <= '0;
                        end
                        OP_CLEAR_FAULT: fault_q  <= 1'b0;
                        default:        ;
                    endcase
                    state_q <= S_IDLE;
                end
                S_REJECT: begin
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SOFT_RAMP_EN
    localparam int DIV_W = $clog2(RAMP_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(RAMP_STEP);

    logic [DUTY_W-1:0] duty_q;
    logic [DIV_W-1:0]  div_q;
    logic              zero_duty;

    assign zero_duty = wd_expire | ((state_q == S_EXEC) && (op_q == OP_ESTOP));

    // Emergency paths bypass the ramp; otherwise step once per divider wrap.
    always_ff @(posedge CLK) begin
        if (CLR || zero_duty) begin
            duty_q <= '0;
            div_q  <= '0;
        end else if (duty_q == target_q) begin
            div_q <= '0;
        end else if (div_q != DIV_LAST) begin
            div_q <= div_q + DIV_W'(1);
        end else begin
            div_q <= '0;
            if (duty_q < target_q) begin
                duty_q <= ((target_q - duty_q) <= STEP) ? target_q : duty_q + STEP;
            end else begin
                duty_q <= ((duty_q - target_q) <= STEP) ? target_q : duty_q - STEP;
            end
        end
    end

    assign Duty = duty_q;
`else
    localparam int unused_ramp_cfg = RAMP_DIV + RAMP_STEP;

    assign Duty = target_q;
`endif

    assign Dir       = dir_q;
    assign Motor_EN  = en_q;
    assign Fault     = fault_q;
    assign Link_Lost = lost_q;
    assign Cmd_Valid = cmd_valid_q;
    assign Err_Count = err_cnt_q;

endmodule

// File: doc/rx_command_sequencer.md
Name: rx_command_sequencer

Overview:
- Consumes 32-bit words from the synchronous serial receiver (Data, Data_Ready, Parity_ERR) and validates each frame: parity, header, opcode.
- Decodes each accepted frame into motor-control configuration (duty, direction, enable, e-stop) for the BLDC commutation/PWM stage.
- Runs a link watchdog that forces the motor off when valid traffic stops.
- Sits between the receiver and the PWM/commutation logic; all outputs are registered.

Parameters:
- DUTY_W, 10, width of the duty command/output.
- DUTY_MAX, 1000, duty clamp value (payload above this is clamped).
- HEADER, 8'hA5, required value of frame bits [31:24].
- TIMEOUT_CYC, 5000000, CLK cycles without an accepted frame before link loss (100 ms at 50 MHz).
- RAMP_DIV, 5000, CLK cycles per ramp step (used only with SOFT_RAMP_EN).
- RAMP_STEP, 1, duty increment/decrement per ramp step (used only with SOFT_RAMP_EN).

Ports:
- CLK  in  1  system clock.
- CLR  in  1  reset; synchronous, active-high.
- Data_Ready  in  1  receiver word-ready; level held for about one baud period, only its rising edge is used.
- Data  in  32  receiver word.
- Parity_ERR  in  1  receiver parity-error flag, valid while Data_Ready is high.
- Duty  out  DUTY_W  applied duty to PWM.
- Dir  out  1  rotation direction.
- Motor_EN  out  1  motor drive enable.
- Fault  out  1  latched e-stop.
- Link_Lost  out  1  watchdog expired.
- Cmd_Valid  out  1  one-cycle pulse per executed command.
- Err_Count  out  8  rejected-frame count, saturating.

Behaviour:
- Frame format: [31:24] header; [23:20] opcode; [19:16] reserved (ignored); [15:0] payload.
- Opcodes:
  - 1 SET_DUTY: target = min(payload, DUTY_MAX), truncated to DUTY_W.
  - 2 SET_DIR: Dir = payload[0].
  - 3 ENABLE: Motor_EN = 1.
  - 4 DISABLE: Motor_EN = 0.
  - 5 ESTOP: Fault = 1, Motor_EN = 0, target = 0, Duty = 0.
  - 6 HEARTBEAT: no-op.
  - 7 CLEAR_FAULT: Fault = 0.
  - All other opcodes are invalid.
- Edge detect: a registered copy of Data_Ready is kept; rise = Data_Ready & ~prev.
- FSM states: IDLE, LATCH, CHECK, EXEC, REJECT.
  - IDLE: on rise, capture Data and Parity_ERR into internal registers, go to LATCH.
  - LATCH: go to CHECK. This cycle is a pipeline stage only.
  - CHECK: if Parity_ERR, header mismatch or invalid opcode, go to REJECT; else go to EXEC.
  - EXEC: apply the opcode, pulse Cmd_Valid, clear the watchdog, clear Link_Lost, go to IDLE.
  - REJECT: Err_Count += 1 (holds at 255), go to IDLE. Cmd_Valid stays 0 and the watchdog is not cleared.
- Latency: rise sampled at edge N; register updates and Cmd_Valid are visible after edge N+3.
- A rise outside IDLE is ignored. It cannot occur at legal baud ratios.
- ENABLE while Fault = 1 is treated as rejected: counts in Err_Count, Motor_EN stays 0, Cmd_Valid is not pulsed.
- Watchdog:
  - The counter increments every cycle, saturating at TIMEOUT_CYC.
  - It reaches TIMEOUT_CYC after TIMEOUT_CYC cycles with no EXEC. Then Link_Lost = 1, Motor_EN = 0, target = 0, Duty = 0.
  - A later EXEC clears Link_Lost but does not re-enable the motor; a separate ENABLE is required.
- Simultaneous events: if EXEC and watchdog expiry fall in the same cycle, EXEC wins and the counter clears.
- Duty output: Duty follows target immediately (no ramp).
- Motor_EN = 0 does not clear target; only ESTOP and watchdog expiry zero it.
- Reset (CLR = 1 at any cycle, including mid-FSM):
  - State goes to IDLE; any captured frame is discarded.
  - Duty = 0, target = 0, Dir = 0, Motor_EN = 0, Fault = 0, Link_Lost = 0, Cmd_Valid = 0, Err_Count = 0, watchdog = 0, edge register = 0.

Optional Feature:
- Macro: SOFT_RAMP_EN.
- Defined:
  - Duty moves toward target by RAMP_STEP once every RAMP_DIV cycles.
  - A step never overshoots; the final step lands exactly on target.
  - The ramp divider runs only while Duty != target.
  - ESTOP, watchdog expiry and CLR zero Duty immediately, bypassing the ramp.
- Not defined: Duty = target one cycle after it changes (same cycle as the other EXEC outputs). The ramp logic is absent.

Test Plan:
- Reset, then ENABLE frame 32'hA530_0000, then SET_DUTY 32'hA510_0190: Motor_EN = 1, Duty = 400, two Cmd_Valid pulses, each 3 edges after its rise.
- SET_DUTY 32'hA510_FFFF: Duty = 1000 (clamped). Then frame 32'h5A10_0064: rejected, Err_Count = 1, Duty stays 1000.
- Valid frame with Parity_ERR = 1: Err_Count increments, no Cmd_Valid. Then 260 bad frames: Err_Count = 255.
- ESTOP 32'hA550_0000 with Motor_EN = 1: Duty = 0, Fault = 1, Motor_EN = 0.
  - Then ENABLE: rejected, Motor_EN = 0.
  - Then CLEAR_FAULT (32'hA570_0000) followed by ENABLE: Motor_EN = 1.
- TIMEOUT_CYC = 1000, enabled with duty 300, no traffic for 1000 cycles: Link_Lost = 1, Motor_EN = 0, Duty = 0.
  - Then HEARTBEAT: Link_Lost = 0, Motor_EN = 0.
- CLR asserted during CHECK of a SET_DUTY 500 frame: Duty stays 0, no Cmd_Valid, all outputs at reset values.
  - With SOFT_RAMP_EN, RAMP_DIV = 4: duty 0 to 3 steps by 1 every 4 cycles, Duty = 3 after 12 cycles.
